// File: rtl/rob_commit_unit_if.sv
// Rename/write-back/commit bundle of the reorder buffer.
// master = rename + write-back side, slave = the ROB itself.
`ifndef ARCH_REG_NUM_WIDTH
`define ARCH_REG_NUM_WIDTH 5
`endif
`ifndef PHYSICAL_REG_NUM_WIDTH
`define PHYSICAL_REG_NUM_WIDTH 6
`endif
`ifndef INST_ADDR_WIDTH
`define INST_ADDR_WIDTH 32
`endif

interface rob_commit_unit_if #(
  parameter int ROB_DEPTH              = 16,
  parameter int ARCH_REG_NUM_WIDTH     = `ARCH_REG_NUM_WIDTH,
  parameter int PHYSICAL_REG_NUM_WIDTH = `PHYSICAL_REG_NUM_WIDTH,
  parameter int INST_ADDR_WIDTH        = `INST_ADDR_WIDTH
);
  localparam int TAG_W = $clog2(ROB_DEPTH);

  logic                              alloc_valid;
  logic                              alloc_ready;
  logic                              alloc_has_dst;
  logic [ARCH_REG_NUM_WIDTH-1:0]     alloc_arch_rd;
  logic [PHYSICAL_REG_NUM_WIDTH-1:0] alloc_phy_rd;
  logic [PHYSICAL_REG_NUM_WIDTH-1:0] alloc_old_phy_rd;
  logic [INST_ADDR_WIDTH-1:0]        alloc_pc;
  logic [TAG_W-1:0]                  alloc_tag;

  logic                              wb_valid;
  logic [TAG_W-1:0]                  wb_tag;
  logic                              wb_exception;

  logic                              commit_valid;
  logic                              commit_with_write;
  logic [PHYSICAL_REG_NUM_WIDTH-1:0] commited_wr_register;
  logic [ARCH_REG_NUM_WIDTH-1:0]     commit_arch_reg;
  logic [PHYSICAL_REG_NUM_WIDTH-1:0] commit_phy_reg;
  logic [INST_ADDR_WIDTH-1:0]        commit_pc;

  logic                              flush;
  logic [INST_ADDR_WIDTH-1:0]        flush_pc;
  logic [TAG_W:0]                    rob_count;
  logic                              rob_empty;

  modport master (
    output alloc_valid, alloc_has_dst, alloc_arch_rd, alloc_phy_rd,
           alloc_old_phy_rd, alloc_pc, wb_valid, wb_tag, wb_exception,
    input  alloc_ready, alloc_tag, commit_valid, commit_with_write,
           commited_wr_register, commit_arch_reg, commit_phy_reg, commit_pc,
           flush, flush_pc, rob_count, rob_empty
  );

  modport slave (
    input  alloc_valid, alloc_has_dst, alloc_arch_rd, alloc_phy_rd,
           alloc_old_phy_rd, alloc_pc, wb_valid, wb_tag, wb_exception,
    output alloc_ready, alloc_tag, commit_valid, commit_with_write,
           commited_wr_register, commit_arch_reg, commit_phy_reg, commit_pc,
           flush, flush_pc, rob_count, rob_empty
  );
endinterface

// File: rtl/rob_commit_unit.sv
// In-order reorder buffer with single-wide commit and exception flush.
// Commit decision is combinational on the head entry; commit/flush outputs are registered.
`ifndef ARCH_REG_NUM_WIDTH
`define ARCH_REG_NUM_WIDTH 5
`endif
`ifndef PHYSICAL_REG_NUM_WIDTH
`define PHYSICAL_REG_NUM_WIDTH 6
`endif
`ifndef INST_ADDR_WIDTH
`define INST_ADDR_WIDTH 32
`endif

module rob_commit_unit #(
  parameter int ROB_DEPTH              = 16,
  parameter int ARCH_REG_NUM_WIDTH     = `ARCH_REG_NUM_WIDTH,
  parameter int PHYSICAL_REG_NUM_WIDTH = `PHYSICAL_REG_NUM_WIDTH,
  parameter int INST_ADDR_WIDTH        = `INST_ADDR_WIDTH
) (
  input logic              clk,
  input logic              reset,
  rob_commit_unit_if.slave rob
);
  localparam int TAG_W = $clog2(ROB_DEPTH);
  localparam logic [TAG_W:0] FULL_CNT = (TAG_W+1)'(ROB_DEPTH);

  logic [TAG_W-1:0] head;
  logic [TAG_W-1:0] tail;
  logic [TAG_W:0]   count;

  logic [ROB_DEPTH-1:0] busy;
  logic [ROB_DEPTH-1:0] done;
  logic [ROB_DEPTH-1:0] exc;

  logic                              has_dst_q    [ROB_DEPTH];
  logic [ARCH_REG_NUM_WIDTH-1:0]     arch_rd_q    [ROB_DEPTH];
  logic [PHYSICAL_REG_NUM_WIDTH-1:0] phy_rd_q     [ROB_DEPTH];
  logic [PHYSICAL_REG_NUM_WIDTH-1:0] old_phy_rd_q [ROB_DEPTH];
  logic [INST_ADDR_WIDTH-1:0]        pc_q         [ROB_DEPTH];

  logic                              commit_valid_q;
  logic                              commit_with_write_q;
  logic [PHYSICAL_REG_NUM_WIDTH-1:0] commited_wr_register_q;
  logic [ARCH_REG_NUM_WIDTH-1:0]     commit_arch_reg_q;
  logic [PHYSICAL_REG_NUM_WIDTH-1:0] commit_phy_reg_q;
  logic [INST_ADDR_WIDTH-1:0]        commit_pc_q;
  logic                              flush_q;
  logic [INST_ADDR_WIDTH-1:0]        flush_pc_q;

  logic alloc_ready;
  logic head_done;
  logic retire;
  logic take_flush;
  logic alloc_ok;
  logic wb_ok;
  logic [TAG_W:0] count_nxt;

  assign alloc_ready = (count != FULL_CNT);
  assign head_done   = busy[head] && done[head];
  assign retire      = head_done && !exc[head];
  assign take_flush  = head_done && exc[head];

  // A flush discards everything else that happens in its cycle.
  assign alloc_ok = rob.alloc_valid && alloc_ready && !take_flush;
  assign wb_ok    = rob.wb_valid && !take_flush && busy[rob.wb_tag]
                    && !(alloc_ok && (rob.wb_tag == tail));

  always_comb begin
    count_nxt = count;
    case ({alloc_ok, retire})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (take_flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (retire)   head <= head + 1'b1;
      if (alloc_ok) tail <= tail + 1'b1;
      count <= count_nxt;
    end
  end

  // Allocation is written last so it overrides any write-back to the same slot.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy <= '0;
      done <= '0;
      exc  <= '0;
    end else if (take_flush) begin
      busy <= '0;
      done <= '0;
      exc  <= '0;
    end else begin
      if (retire) busy[head] <= 1'b0;
      if (wb_ok) begin
        done[rob.wb_tag] <= 1'b1;
        exc[rob.wb_tag]  <= rob.wb_exception;
      end
      if (alloc_ok) begin
        busy[tail] <= 1'b1;
        done[tail] <= 1'b0;
        exc[tail]  <= 1'b0;
      end
    end
  end

  // Payload is qualified by busy, so it needs no reset.
  always_ff @(posedge clk) begin
    if (alloc_ok) begin
      has_dst_q[tail]    <= rob.alloc_has_dst;
      arch_rd_q[tail]    <= rob.alloc_arch_rd;
      phy_rd_q[tail]     <= rob.alloc_phy_rd;
      old_phy_rd_q[tail] <= rob.alloc_old_phy_rd;
      pc_q[tail]         <= rob.alloc_pc;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      commit_valid_q         <= 1'b0;
      commit_with_write_q    <= 1'b0;
      commited_wr_register_q <= '0;
      commit_arch_reg_q      <= '0;
      commit_phy_reg_q       <= '0;
      commit_pc_q            <= '0;
      flush_q                <= 1'b0;
      flush_pc_q             <= '0;
    end else begin
      commit_valid_q <= retire;
      flush_q        <= take_flush;
      if (retire) begin
        commit_with_write_q    <= has_dst_q[head];
        commited_wr_register_q <= old_phy_rd_q[head];
        commit_arch_reg_q      <= arch_rd_q[head];
        commit_phy_reg_q       <= phy_rd_q[head];
        commit_pc_q            <= pc_q[head];
      end
      if (take_flush) flush_pc_q <= pc_q[head];
    end
  end

  assign rob.alloc_ready          = alloc_ready;
  assign rob.alloc_tag            = tail;
  assign rob.rob_count            = count;
  assign rob.rob_empty            = (count == '0);
  assign rob.commit_valid         = commit_valid_q;
  assign rob.commit_with_write    = commit_with_write_q;
  assign rob.commited_wr_register = commited_wr_register_q;
  assign rob.commit_arch_reg      = commit_arch_reg_q;
  assign rob.commit_phy_reg       = commit_phy_reg_q;
  assign rob.commit_pc            = commit_pc_q;
  assign rob.flush                = flush_q;
  assign rob.flush_pc             = flush_pc_q;
endmodule

// File: tb/tb_rob_commit_unit.sv
// Directed bench for rob_commit_unit: commits are checked against a queue of
// expected entries pushed at allocation time.
module tb_rob_commit_unit;
  localparam int DEPTH = 16;
  localparam int AW    = 5;
  localparam int PW    = 6;
  localparam int IW    = 32;

  typedef struct packed {
    logic          has_dst;
    logic [AW-1:0] arch;
    logic [PW-1:0] phy;
    logic [PW-1:0] old;
    logic [IW-1:0] pc;
  } exp_t;

  logic clk;
  logic reset;
  exp_t sb[$];
  int   n_assert;
  int   n_fail;
  logic [3:0]    m_tail;
  logic [IW-1:0] exp_flush_pc;

  rob_commit_unit_if #(
    .ROB_DEPTH(DEPTH), .ARCH_REG_NUM_WIDTH(AW),
    .PHYSICAL_REG_NUM_WIDTH(PW), .INST_ADDR_WIDTH(IW)
  ) bus ();

  rob_commit_unit #(
    .ROB_DEPTH(DEPTH), .ARCH_REG_NUM_WIDTH(AW),
    .PHYSICAL_REG_NUM_WIDTH(PW), .INST_ADDR_WIDTH(IW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .rob  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input logic exp_cv, input logic exp_fl);
    exp_t e;
    @(posedge clk);
    #1;
    chk("commit_valid", 32'(bus.commit_valid), 32'(exp_cv));
    chk("flush", 32'(bus.flush), 32'(exp_fl));
    if (exp_fl) chk("flush_pc", bus.flush_pc, exp_flush_pc);
    if (exp_cv) begin
      if (sb.size() == 0) begin
        chk("scoreboard_nonempty", 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        chk("commit_with_write", 32'(bus.commit_with_write), 32'(e.has_dst));
        chk("commited_wr_register", 32'(bus.commited_wr_register), 32'(e.old));
        chk("commit_arch_reg", 32'(bus.commit_arch_reg), 32'(e.arch));
        chk("commit_phy_reg", 32'(bus.commit_phy_reg), 32'(e.phy));
        chk("commit_pc", bus.commit_pc, e.pc);
      end
    end
  endtask

  task automatic drive_alloc(input logic has, input logic [AW-1:0] arch,
                             input logic [PW-1:0] phy, input logic [PW-1:0] old,
                             input logic [IW-1:0] pc);
    bus.alloc_valid      = 1'b1;
    bus.alloc_has_dst    = has;
    bus.alloc_arch_rd    = arch;
    bus.alloc_phy_rd     = phy;
    bus.alloc_old_phy_rd = old;
    bus.alloc_pc         = pc;
  endtask

  // Drives an allocation that must be accepted and records its expected commit.
  task automatic alloc_one(input logic has, input logic [AW-1:0] arch,
                           input logic [PW-1:0] phy, input logic [PW-1:0] old,
                           input logic [IW-1:0] pc);
    exp_t e;
    drive_alloc(has, arch, phy, old, pc);
    chk("alloc_ready", 32'(bus.alloc_ready), 32'd1);
    chk("alloc_tag", 32'(bus.alloc_tag), 32'(m_tail));
    e.has_dst = has; e.arch = arch; e.phy = phy; e.old = old; e.pc = pc;
    sb.push_back(e);
    m_tail = m_tail + 4'd1;
  endtask

  task automatic set_wb(input logic [3:0] tag, input logic ex);
    bus.wb_valid     = 1'b1;
    bus.wb_tag       = tag;
    bus.wb_exception = ex;
  endtask

  task automatic clr_wb();
    bus.wb_valid     = 1'b0;
    bus.wb_exception = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #2;
    reset  = 1'b1;
    m_tail = '0;
    sb.delete();
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    m_tail   = '0;
    exp_flush_pc = '0;
    reset = 1'b0;
    bus.alloc_valid = 1'b0; bus.alloc_has_dst = 1'b0; bus.alloc_arch_rd = '0;
    bus.alloc_phy_rd = '0; bus.alloc_old_phy_rd = '0; bus.alloc_pc = '0;
    bus.wb_valid = 1'b0; bus.wb_tag = '0; bus.wb_exception = 1'b0;
    #1;
    chk("rst_count", 32'(bus.rob_count), 32'd0);
    chk("rst_empty", 32'(bus.rob_empty), 32'd1);
    chk("rst_ready", 32'(bus.alloc_ready), 32'd1);
    chk("rst_commit_valid", 32'(bus.commit_valid), 32'd0);
    chk("rst_flush", 32'(bus.flush), 32'd0);
    chk("rst_commited_wr_register", 32'(bus.commited_wr_register), 32'd0);
    chk("rst_commit_pc", bus.commit_pc, 32'd0);
    chk("rst_flush_pc", bus.flush_pc, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;

    // Out-of-order write-back, in-order commit.
    alloc_one(1'b1, 5'd1, 6'd20, 6'd7, 32'h100); tick(0, 0);
    alloc_one(1'b1, 5'd2, 6'd21, 6'd8, 32'h104); tick(0, 0);
    alloc_one(1'b1, 5'd3, 6'd22, 6'd9, 32'h108); tick(0, 0);
    bus.alloc_valid = 1'b0;
    chk("ooo_count", 32'(bus.rob_count), 32'd3);
    set_wb(4'd2, 1'b0); tick(0, 0);
    set_wb(4'd0, 1'b0); tick(0, 0);
    set_wb(4'd1, 1'b0); tick(1, 0);
    clr_wb();           tick(1, 0);
    tick(1, 0);
    tick(0, 0);
    chk("ooo_drained", 32'(bus.rob_count), 32'd0);
    chk("ooo_empty", 32'(bus.rob_empty), 32'd1);

    // Store: no destination, old mapping still reported.
    alloc_one(1'b0, 5'd0, 6'd30, 6'd12, 32'h200); tick(0, 0);
    bus.alloc_valid = 1'b0;
    set_wb(4'd3, 1'b0); tick(0, 0);
    clr_wb();           tick(1, 0);
    tick(0, 0);

    // Asynchronous reset with 5 entries occupied and a commit pending.
    for (int i = 0; i < 5; i++) begin
      drive_alloc(1'b1, 5'(i + 4), 6'(i + 40), 6'(i + 1), 32'h280 + 32'(4 * i));
      chk("mid_tag", 32'(bus.alloc_tag), 32'(m_tail));
      m_tail = m_tail + 4'd1;
      tick(0, 0);
    end
    bus.alloc_valid = 1'b0;
    chk("mid_count", 32'(bus.rob_count), 32'd5);
    set_wb(4'd4, 1'b0); tick(0, 0);
    clr_wb();
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_count", 32'(bus.rob_count), 32'd0);
    chk("mid_rst_empty", 32'(bus.rob_empty), 32'd1);
    chk("mid_rst_ready", 32'(bus.alloc_ready), 32'd1);
    chk("mid_rst_commit_valid", 32'(bus.commit_valid), 32'd0);
    chk("mid_rst_flush", 32'(bus.flush), 32'd0);
    chk("mid_rst_tag", 32'(bus.alloc_tag), 32'd0);
    @(posedge clk);
    #1;
    chk("mid_rst_no_pulse", 32'(bus.commit_valid), 32'd0);
    reset  = 1'b1;
    m_tail = '0;
    tick(0, 0);

    // Fill, back-pressure, partial drain, wrap-around.
    for (int i = 0; i < 16; i++) begin
      alloc_one(1'b1, 5'(i + 1), 6'(32 + i), 6'(i), 32'h1000 + 32'(4 * i));
      tick(0, 0);
    end
    bus.alloc_valid = 1'b0;
    chk("full_ready", 32'(bus.alloc_ready), 32'd0);
    chk("full_count", 32'(bus.rob_count), 32'd16);
    drive_alloc(1'b1, 5'd31, 6'd63, 6'd63, 32'hdead);
    tick(0, 0);
    bus.alloc_valid = 1'b0;
    chk("full_refused_count", 32'(bus.rob_count), 32'd16);
    for (int i = 0; i < 4; i++) begin
      set_wb(4'(i), 1'b0);
      tick(i != 0, 0);
    end
    clr_wb(); tick(1, 0);
    chk("partial_count", 32'(bus.rob_count), 32'd12);
    chk("partial_ready", 32'(bus.alloc_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      chk("wrap_tag", 32'(bus.alloc_tag), 32'(i));
      alloc_one(1'b1, 5'(20 + i), 6'(50 + i), 6'(40 + i), 32'h2000 + 32'(4 * i));
      tick(0, 0);
    end
    bus.alloc_valid = 1'b0;
    chk("wrap_count", 32'(bus.rob_count), 32'd16);
    for (int i = 0; i < 16; i++) begin
      set_wb(4'(i + 4), 1'b0);
      tick(i != 0, 0);
    end
    clr_wb(); tick(1, 0);
    tick(0, 0);
    chk("wrap_drained", 32'(bus.rob_count), 32'd0);
    chk("wrap_empty", 32'(bus.rob_empty), 32'd1);

    // Exception flush.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      alloc_one(1'b1, 5'(i + 1), 6'(10 + i), 6'(i + 2), 32'h300 + 32'(4 * i));
      tick(0, 0);
    end
    bus.alloc_valid = 1'b0;
    set_wb(4'd1, 1'b1); tick(0, 0);
    set_wb(4'd0, 1'b0); tick(0, 0);
    clr_wb();           tick(1, 0);
    drive_alloc(1'b1, 5'd7, 6'd33, 6'd3, 32'h400);
    chk("flush_cycle_ready", 32'(bus.alloc_ready), 32'd1);
    exp_flush_pc = 32'h304;
    tick(0, 1);
    bus.alloc_valid = 1'b0;
    sb.delete();
    m_tail = '0;
    chk("flush_count", 32'(bus.rob_count), 32'd0);
    chk("flush_empty", 32'(bus.rob_empty), 32'd1);
    chk("flush_tail", 32'(bus.alloc_tag), 32'd0);
    tick(0, 0);
    chk("flush_alloc_dropped", 32'(bus.rob_count), 32'd0);

    // Write-back colliding with allocation of the same slot is lost.
    alloc_one(1'b1, 5'd9, 6'd44, 6'd45, 32'h500);
    set_wb(4'd0, 1'b0);
    tick(0, 0);
    bus.alloc_valid = 1'b0;
    clr_wb();
    tick(0, 0);
    tick(0, 0);
    chk("collide_count", 32'(bus.rob_count), 32'd1);
    set_wb(4'd0, 1'b0); tick(0, 0);
    clr_wb();           tick(1, 0);
    chk("collide_drained", 32'(bus.rob_count), 32'd0);

    // Full ROB retiring while allocation is requested.
    for (int i = 0; i < 16; i++) begin
      alloc_one(1'b1, 5'(i), 6'(i + 16), 6'(i + 3), 32'h600 + 32'(4 * i));
      tick(0, 0);
    end
    bus.alloc_valid = 1'b0;
    chk("sim_full_count", 32'(bus.rob_count), 32'd16);
    set_wb(4'd1, 1'b0); tick(0, 0);
    clr_wb();
    drive_alloc(1'b1, 5'd9, 6'd60, 6'd61, 32'h700);
    chk("sim_refused_ready", 32'(bus.alloc_ready), 32'd0);
    tick(1, 0);
    chk("sim_count_after_retire", 32'(bus.rob_count), 32'd15);
    chk("sim_ready_back", 32'(bus.alloc_ready), 32'd1);
    alloc_one(1'b1, 5'd9, 6'd60, 6'd61, 32'h700);
    tick(0, 0);
    bus.alloc_valid = 1'b0;
    chk("sim_count_refilled", 32'(bus.rob_count), 32'd16);
    chk("sim_ready_full", 32'(bus.alloc_ready), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
